// File: rtl/register_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_scoreboard_pkg
// Description : Shared defaults for the decode-stage register scoreboard and
//               the producer-latency constants decode uses to drive
//               dec_latency (ALU=0, load=2, mul=4).
// Revision    : 1.0 - initial release
// ============================================================================
package register_scoreboard_pkg;

    localparam int c_num_regs    = 32;
    localparam int c_reg_idx_w   = 5;
    localparam int c_max_latency = 7;
    localparam int c_lat_w       = 3;

    // Producer classes seen by decode.
    typedef enum logic [1:0] {
        OP_ALU  = 2'd0,
        OP_LOAD = 2'd1,
        OP_MUL  = 2'd2
    } op_class_e;

    localparam logic [c_lat_w-1:0] c_lat_alu  = 3'd0;
    localparam logic [c_lat_w-1:0] c_lat_load = 3'd2;
    localparam logic [c_lat_w-1:0] c_lat_mul  = 3'd4;

    // Latency decode should present for a given producer class.
    function automatic logic [c_lat_w-1:0] op_latency(input op_class_e op);
        logic [c_lat_w-1:0] lat;
        lat = c_lat_alu;
        case (op)
            OP_LOAD: lat = c_lat_load;
            OP_MUL:  lat = c_lat_mul;
            default: lat = c_lat_alu;
        endcase
        return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_scoreboard_entry.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_entry
// Description : Pending bit and forwarding down-counter for one register.
//               Priority: flush > set (issue) > clear (writeback) > decrement.
// Ports       : clk, rst_n (async active-low)
//               i_set / i_lat  : record an issued producer with latency i_lat
//               i_clr          : writeback commit (ignored when not pending)
//               i_flush        : drop the in-flight producer
//               i_dec          : count enable for the remaining-latency counter
//               o_pending      : registered pending bit
//               o_remaining    : registered cycles until forwardable
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_entry
    import register_scoreboard_pkg::*;
#(
    parameter int LAT_W = c_lat_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_set,
    input  logic             i_clr,
    input  logic             i_flush,
    input  logic             i_dec,
    input  logic [LAT_W-1:0] i_lat,
    output logic             o_pending,
    output logic [LAT_W-1:0] o_remaining
);

    logic             r_pending;
    logic [LAT_W-1:0] r_remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= 1'b0;
            r_remaining <= '0;
        end else if (i_flush) begin
            r_pending   <= 1'b0;
            r_remaining <= '0;
        end else if (i_set) begin
            // Issue beats a same-cycle writeback: the new producer owns the entry.
            r_pending   <= 1'b1;
            r_remaining <= i_lat;
        end else if (i_clr && r_pending) begin
            r_pending   <= 1'b0;
            r_remaining <= '0;
        end else if (i_dec && r_pending && (r_remaining != '0)) begin
            r_remaining <= r_remaining - 1'b1;
        end
    end

    assign o_pending   = r_pending;
    assign o_remaining = r_remaining;

endmodule
`default_nettype wire

// File: rtl/register_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : register_scoreboard
// Description : Decode-stage register scoreboard. Tracks a pending bit and a
//               remaining-latency counter per architectural register and
//               raises a combinational stall for RAW hazards and for WAW
//               hazards where an older producer would complete after a
//               younger one. Register 0 is hardwired zero, never pending.
// Config      : SCOREBOARD_FORWARDING_EN - when defined a pending source is
//               ready once its counter reaches zero; otherwise a source is
//               ready only after writeback.
// Ports       : clk, rst_n (async active-low)
//               dec_*          : operands/destination of the op in decode
//               wb_valid/wb_idx: committed register-file write
//               flush          : discard every in-flight producer
//               stall          : hold decode (combinational)
//               busy_mask      : registered pending bit per register
//               pending_count  : popcount of busy_mask
// Revision    : 1.0 - initial release
// ============================================================================
module register_scoreboard
    import register_scoreboard_pkg::*;
#(
    parameter int NUM_REGS             = c_num_regs,
    parameter int REGISTER_INDEX_WIDTH = c_reg_idx_w,
    parameter int MAX_LATENCY          = c_max_latency,
    parameter int LAT_W                = c_lat_w
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            dec_valid,
    input  logic [REGISTER_INDEX_WIDTH-1:0] dec_src1_idx,
    input  logic                            dec_src1_used,
    input  logic [REGISTER_INDEX_WIDTH-1:0] dec_src2_idx,
    input  logic                            dec_src2_used,
    input  logic [REGISTER_INDEX_WIDTH-1:0] dec_dst_idx,
    input  logic                            dec_dst_we,
    input  logic [LAT_W-1:0]                dec_latency,
    input  logic                            wb_valid,
    input  logic [REGISTER_INDEX_WIDTH-1:0] wb_idx,
    input  logic                            flush,
    output logic                            stall,
    output logic [NUM_REGS-1:0]             busy_mask,
    output logic [REGISTER_INDEX_WIDTH:0]   pending_count
);

    localparam logic [LAT_W-1:0] c_max_lat = LAT_W'(MAX_LATENCY);

    logic [NUM_REGS-1:0]         w_pending;
    logic [LAT_W-1:0]            w_remaining [NUM_REGS];
    logic                        w_issue;
    logic                        w_raw;
    logic                        w_waw;
    logic                        w_src1_ready;
    logic                        w_src2_ready;
    logic                        w_dst_nonzero;
    logic [LAT_W-1:0]            w_rem_dst;
    logic [REGISTER_INDEX_WIDTH:0] w_count;

    // ------------------------------------------------------------------
    // Per-register state. Entry 0 is the zero register and is tied off.
    // ------------------------------------------------------------------
    assign w_pending[0]   = 1'b0;
    assign w_remaining[0] = '0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
            logic w_set;
            logic w_clr;

            assign w_set = w_issue  && (dec_dst_idx == REGISTER_INDEX_WIDTH'(gi));
            assign w_clr = wb_valid && (wb_idx      == REGISTER_INDEX_WIDTH'(gi));

            scoreboard_entry #(
                .LAT_W       (LAT_W)
            ) u_entry (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_set       (w_set),
                .i_clr       (w_clr),
                .i_flush     (flush),
                .i_dec       (1'b1),
                .i_lat       (dec_latency),
                .o_pending   (w_pending[gi]),
                .o_remaining (w_remaining[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Source readiness
    // ------------------------------------------------------------------
`ifdef SCOREBOARD_FORWARDING_EN
    logic [LAT_W-1:0] w_rem_src1;
    logic [LAT_W-1:0] w_rem_src2;

    assign w_rem_src1   = w_remaining[dec_src1_idx];
    assign w_rem_src2   = w_remaining[dec_src2_idx];
    assign w_src1_ready = (dec_src1_idx == '0) || !w_pending[dec_src1_idx] || (w_rem_src1 == '0);
    assign w_src2_ready = (dec_src2_idx == '0) || !w_pending[dec_src2_idx] || (w_rem_src2 == '0);
`else
    assign w_src1_ready = (dec_src1_idx == '0) || !w_pending[dec_src1_idx];
    assign w_src2_ready = (dec_src2_idx == '0) || !w_pending[dec_src2_idx];
`endif

    // ------------------------------------------------------------------
    // Hazard detection and issue
    // ------------------------------------------------------------------
    assign w_raw = (dec_src1_used && !w_src1_ready) || (dec_src2_used && !w_src2_ready);

    // An older producer that still has more cycles to run than the new one
    // would land its result after the younger write; hold the younger op.
    assign w_dst_nonzero = (dec_dst_idx != '0);
    assign w_rem_dst     = w_remaining[dec_dst_idx];
    assign w_waw         = dec_dst_we && w_dst_nonzero && w_pending[dec_dst_idx]
                           && (w_rem_dst > dec_latency);

    assign stall   = dec_valid && !flush && (w_raw || w_waw);
    assign w_issue = dec_valid && !stall && !flush && dec_dst_we && w_dst_nonzero;

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_count = w_count + (REGISTER_INDEX_WIDTH+1)'(w_pending[i]);
        end
    end

    assign busy_mask     = w_pending;
    assign pending_count = w_count;

    // Latencies beyond the configured maximum have no defined behaviour.
    a_latency_range : assert property (@(posedge clk) disable iff (!rst_n)
        !(dec_valid && dec_dst_we && (dec_latency > c_max_lat)));

endmodule
`default_nettype wire

// File: tb/tb_register_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_scoreboard
// Description : Directed self-checking bench for register_scoreboard.
//               Expectations follow the SCOREBOARD_FORWARDING_EN setting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_scoreboard;
    import register_scoreboard_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        dec_valid;
    logic [4:0]  dec_src1_idx;
    logic        dec_src1_used;
    logic [4:0]  dec_src2_idx;
    logic        dec_src2_used;
    logic [4:0]  dec_dst_idx;
    logic        dec_dst_we;
    logic [2:0]  dec_latency;
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic        flush;
    logic        stall;
    logic [31:0] busy_mask;
    logic [5:0]  pending_count;

    int n_tests;
    int n_fail;

    register_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dec_valid     (dec_valid),
        .dec_src1_idx  (dec_src1_idx),
        .dec_src1_used (dec_src1_used),
        .dec_src2_idx  (dec_src2_idx),
        .dec_src2_used (dec_src2_used),
        .dec_dst_idx   (dec_dst_idx),
        .dec_dst_we    (dec_dst_we),
        .dec_latency   (dec_latency),
        .wb_valid      (wb_valid),
        .wb_idx        (wb_idx),
        .flush         (flush),
        .stall         (stall),
        .busy_mask     (busy_mask),
        .pending_count (pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        dec_valid     = 1'b0;
        dec_src1_idx  = '0;
        dec_src1_used = 1'b0;
        dec_src2_idx  = '0;
        dec_src2_used = 1'b0;
        dec_dst_idx   = '0;
        dec_dst_we    = 1'b0;
        dec_latency   = '0;
        wb_valid      = 1'b0;
        wb_idx        = '0;
        flush         = 1'b0;
    endtask

    task automatic drive_op(input logic [4:0] s1, input logic u1,
                            input logic [4:0] s2, input logic u2,
                            input logic [4:0] d, input logic we,
                            input logic [2:0] lat);
        dec_valid     = 1'b1;
        dec_src1_idx  = s1;
        dec_src1_used = u1;
        dec_src2_idx  = s2;
        dec_src2_used = u2;
        dec_dst_idx   = d;
        dec_dst_we    = we;
        dec_latency   = lat;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        drive_op(5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 3'd2);
        flush = 1'b0;
        settle();
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
        n_tests++;
        if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
        n_tests++;
        if (pending_count !== 6'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", pending_count); end
        idle();
    endtask

    // add x3 (L=0) then sub x4,x3,x1
    task automatic test_alu_forward();
        do_reset();
        drive_op(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, op_latency(OP_ALU));
        settle();
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_issue_stall got=%b exp=0", stall); end
        tick();
        n_tests++;
        if (busy_mask[3] !== 1'b1 || pending_count !== 6'd1) begin
            n_fail++; $display("FAIL alu_x3_pending busy=%h cnt=%0d exp busy[3]=1 cnt=1", busy_mask, pending_count);
        end
        drive_op(5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, op_latency(OP_ALU));
        settle();
`ifdef SCOREBOARD_FORWARDING_EN
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_fwd_stall got=%b exp=0", stall); end
        tick();
        n_tests++;
        if (busy_mask !== 32'h18 || pending_count !== 6'd2) begin
            n_fail++; $display("FAIL alu_fwd_after busy=%h cnt=%0d exp busy=18 cnt=2", busy_mask, pending_count);
        end
`else
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL alu_nofwd_stall1 got=%b exp=1", stall); end
        tick();
        wb_valid = 1'b1;
        wb_idx   = 5'd3;
        settle();
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL alu_nofwd_stall_wb got=%b exp=1", stall); end
        tick();
        wb_valid = 1'b0;
        settle();
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_nofwd_release got=%b exp=0", stall); end
        tick();
        n_tests++;
        if (busy_mask !== 32'h10 || pending_count !== 6'd1) begin
            n_fail++; $display("FAIL alu_nofwd_after busy=%h cnt=%0d exp busy=10 cnt=1", busy_mask, pending_count);
        end
`endif
        idle();
    endtask

    // load x5 (L=2) then dependent consumer
    task automatic test_load_use();
        do_reset();
        drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, op_latency(OP_LOAD));
        tick();
        drive_op(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 3'd0);
        for (int k = 0; k < 2; k++) begin
            settle();
            n_tests++;
            if (stall !== 1'b1) begin n_fail++; $display("FAIL load_stall_c%0d got=%b exp=1", k, stall); end
            tick();
        end
        settle();
`ifdef SCOREBOARD_FORWARDING_EN
        n_tests++;
        if (stall !== 1'b0 || busy_mask[5] !== 1'b1) begin
            n_fail++; $display("FAIL load_fwd_release stall=%b busy5=%b exp stall=0 busy5=1", stall, busy_mask[5]);
        end
        tick();
        dec_valid = 1'b0;
        wb_valid  = 1'b1;
        wb_idx    = 5'd5;
        tick();
        wb_valid  = 1'b0;
`else
        n_tests++;
        if (stall !== 1'b1 || busy_mask[5] !== 1'b1) begin
            n_fail++; $display("FAIL load_nofwd_hold stall=%b busy5=%b exp stall=1 busy5=1", stall, busy_mask[5]);
        end
        wb_valid = 1'b1;
        wb_idx   = 5'd5;
        tick();
        wb_valid = 1'b0;
        settle();
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL load_nofwd_release got=%b exp=0", stall); end
        tick();
        dec_valid = 1'b0;
`endif
        n_tests++;
        if (busy_mask[5] !== 1'b0 || busy_mask[6] !== 1'b1) begin
            n_fail++; $display("FAIL load_final busy=%h exp busy[5]=0 busy[6]=1", busy_mask);
        end
        idle();
    endtask

    // mul x6 (L=4) then add x6 (L=0): WAW hold
    task automatic test_waw();
        do_reset();
        drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, op_latency(OP_MUL));
        tick();
        drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, op_latency(OP_ALU));
        for (int k = 0; k < 4; k++) begin
            settle();
            n_tests++;
            if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall_c%0d got=%b exp=1", k, stall); end
            n_tests++;
            if (pending_count !== 6'd1) begin n_fail++; $display("FAIL waw_count_c%0d got=%0d exp=1", k, pending_count); end
            tick();
        end
        settle();
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL waw_release got=%b exp=0", stall); end
        tick();
        idle();
        n_tests++;
        if (pending_count !== 6'd1 || busy_mask !== 32'h40) begin
            n_fail++; $display("FAIL waw_after busy=%h cnt=%0d exp busy=40 cnt=1", busy_mask, pending_count);
        end
    endtask

    // flush with x2, x7, x9 pending and a same-cycle issue to x10
    task automatic test_flush();
        do_reset();
        drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 3'd1);
        tick();
        drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd3);
        tick();
        drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd5);
        tick();
        n_tests++;
        if (busy_mask !== 32'h284 || pending_count !== 6'd3) begin
            n_fail++; $display("FAIL flush_pre busy=%h cnt=%0d exp busy=284 cnt=3", busy_mask, pending_count);
        end
        // Consumer of pending x7 would stall, but flush forces stall low.
        drive_op(5'd7, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 3'd0);
        flush = 1'b1;
        settle();
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", stall); end
        tick();
        idle();
        settle();
        n_tests++;
        if (busy_mask !== 32'h0 || pending_count !== 6'd0) begin
            n_fail++; $display("FAIL flush_after busy=%h cnt=%0d exp busy=0 cnt=0", busy_mask, pending_count);
        end
    endtask

    // writeback x8 and issue x8 (L=3) in the same cycle
    task automatic test_wb_issue_same();
        do_reset();
        drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 3'd1);
        tick();
        drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 3'd3);
        wb_valid = 1'b1;
        wb_idx   = 5'd8;
        settle();
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL wbiss_stall got=%b exp=0", stall); end
        tick();
        wb_valid = 1'b0;
        n_tests++;
        if (busy_mask !== 32'h100) begin n_fail++; $display("FAIL wbiss_pending busy=%h exp=100", busy_mask); end
        // remaining=3 shows as a 3-cycle WAW hold for an L=0 writer of x8.
        drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 3'd0);
        for (int k = 0; k < 4; k++) begin
            settle();
            n_tests++;
            if (stall !== (k < 3)) begin
                n_fail++; $display("FAIL wbiss_remaining_c%0d got=%b exp=%b", k, stall, (k < 3));
            end
            tick();
        end
        idle();
    endtask

    // x0 operands/destination and a stray writeback
    task automatic test_x0_and_stray_wb();
        do_reset();
        drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 3'd2);
        tick();
        drive_op(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 3'd5);
        wb_valid = 1'b1;
        wb_idx   = 5'd13;
        settle();
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall got=%b exp=0", stall); end
        tick();
        idle();
        n_tests++;
        if (busy_mask !== 32'h1000 || pending_count !== 6'd1) begin
            n_fail++; $display("FAIL x0_state busy=%h cnt=%0d exp busy=1000 cnt=1", busy_mask, pending_count);
        end
        // Writeback to x0 is ignored as well.
        wb_valid = 1'b1;
        wb_idx   = 5'd0;
        tick();
        idle();
        n_tests++;
        if (busy_mask !== 32'h1000) begin n_fail++; $display("FAIL x0_wb busy=%h exp=1000", busy_mask); end
    endtask

    // reset asserted mid-stall
    task automatic test_async_reset();
        do_reset();
        drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd2);
        tick();
        drive_op(5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 3'd0);
        settle();
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL areset_pre_stall got=%b exp=1", stall); end
        rst_n = 1'b0;
        settle();
        n_tests++;
        if (stall !== 1'b0 || busy_mask !== 32'h0 || pending_count !== 6'd0) begin
            n_fail++; $display("FAIL areset_immediate stall=%b busy=%h cnt=%0d exp 0/0/0", stall, busy_mask, pending_count);
        end
        // Issue-shaped op held across an edge while reset is low.
        tick();
        n_tests++;
        if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL areset_edge busy=%h exp=0", busy_mask); end
        rst_n = 1'b1;
        idle();
        tick();
        n_tests++;
        if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL areset_release busy=%h exp=0", busy_mask); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_waw();
        test_flush();
        test_wb_issue_same();
        test_x0_and_stray_wb();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
